// File: rtl/pipeline_ctrl_if.sv
// Pipeline-control bundle: hazard inputs from the datapath and the stage-control outputs.
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_RegDest;
    logic       ex_RegWrite;
    logic       ex_MemRead;
    logic [4:0] mem_RegDest;
    logic       mem_RegWrite;
    logic [4:0] wb_RegDest;
    logic       wb_RegWrite;
    logic       ex_PCSrc;
    logic       mem_busy;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
               ex_RegDest, ex_RegWrite, ex_MemRead, mem_RegDest, mem_RegWrite,
               wb_RegDest, wb_RegWrite, ex_PCSrc, mem_busy,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
               ex_RegDest, ex_RegWrite, ex_MemRead, mem_RegDest, mem_RegWrite,
               wb_RegDest, wb_RegWrite, ex_PCSrc, mem_busy,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for a 5-stage RISC-V pipeline (stalls, flushes, forwarding).
// Optional macro PIPELINE_CTRL_FORWARDING_EN: with it, EX operand forwarding + load-use stalls only;
// without it, no forwarding and any RAW dependency on EX/MEM/WB stalls ID.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    state_t           stateReg, stateNext, effState;
    logic [FCW-1:0]   flushCntReg, flushCntNext;
    logic [CNT_W-1:0] stallCntReg;

    logic       pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush;
    logic       hazard;
    logic [4:0] idRs  [2];
    logic       idUse [2];
    logic       exHit [2];
    logic [1:0] fwdSel [2];

    assign idRs[0]  = bus.id_rs1;
    assign idRs[1]  = bus.id_rs2;
    assign idUse[0] = bus.id_use_rs1;
    assign idUse[1] = bus.id_use_rs2;

`ifdef PIPELINE_CTRL_FORWARDING_EN
    logic [4:0] exRs [2];
    assign exRs[0] = bus.ex_rs1;
    assign exRs[1] = bus.ex_rs2;
`else
    logic memHit [2];
    logic wbHit  [2];
    logic unusedSigs;
    assign unusedSigs = ^{bus.ex_MemRead, bus.ex_rs1, bus.ex_rs2};
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign exHit[gi] = idUse[gi] && bus.ex_RegWrite && (bus.ex_RegDest != 5'd0)
                               && (idRs[gi] == bus.ex_RegDest);
`ifdef PIPELINE_CTRL_FORWARDING_EN
            // MEM result is younger than WB, so it wins when both match.
            assign fwdSel[gi] =
                (bus.mem_RegWrite && (bus.mem_RegDest != 5'd0) && (bus.mem_RegDest == exRs[gi])) ? 2'b01 :
                (bus.wb_RegWrite  && (bus.wb_RegDest  != 5'd0) && (bus.wb_RegDest  == exRs[gi])) ? 2'b10 :
                2'b00;
`else
            assign memHit[gi] = idUse[gi] && bus.mem_RegWrite && (bus.mem_RegDest != 5'd0)
                                && (idRs[gi] == bus.mem_RegDest);
            assign wbHit[gi]  = idUse[gi] && bus.wb_RegWrite && (bus.wb_RegDest != 5'd0)
                                && (idRs[gi] == bus.wb_RegDest);
            assign fwdSel[gi] = 2'b00;
`endif
        end
    endgenerate

`ifdef PIPELINE_CTRL_FORWARDING_EN
    assign hazard = bus.ex_MemRead && (exHit[0] || exHit[1]);
`else
    assign hazard = exHit[0] || exHit[1] || memHit[0] || memHit[1] || wbHit[0] || wbHit[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= RUN;
            flushCntReg <= '0;
        end else begin
            stateReg    <= stateNext;
            flushCntReg <= flushCntNext;
        end
    end

    // Leaving MEM_WAIT resumes whatever was interrupted: a pending flush, or normal running.
    always_comb begin
        effState = stateReg;
        if (stateReg == MEM_WAIT)
            effState = (flushCntReg != '0) ? FLUSH : RUN;
    end

    always_comb begin
        stateNext    = stateReg;
        flushCntNext = flushCntReg;
        if (bus.mem_busy) begin
            stateNext = MEM_WAIT;
        end else if (effState == FLUSH) begin
            flushCntNext = (flushCntReg != '0) ? flushCntReg - FCW'(1) : '0;
            stateNext    = (flushCntReg <= FCW'(1)) ? RUN : FLUSH;
        end else begin
            stateNext = RUN;
            if (bus.ex_PCSrc && (FLUSH_CYCLES > 1)) begin
                flushCntNext = FLUSH_LOAD;
                stateNext    = FLUSH;
            end
        end
    end

    always_comb begin
        pcEn      = 1'b1;
        ifidEn    = 1'b1;
        idexEn    = 1'b1;
        exmemEn   = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        if (!rst_n) begin
            {pcEn, ifidEn, idexEn, exmemEn} = 4'b0000;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (bus.mem_busy) begin
            {pcEn, ifidEn, idexEn, exmemEn} = 4'b0000;
        end else if (effState == FLUSH || bus.ex_PCSrc) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (hazard) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
        end
    end

    assign bus.pc_en      = pcEn;
    assign bus.ifid_en    = ifidEn;
    assign bus.idex_en    = idexEn;
    assign bus.exmem_en   = exmemEn;
    assign bus.ifid_flush = ifidFlush;
    assign bus.idex_flush = idexFlush;
    assign bus.fwd_a      = rst_n ? fwdSel[0] : 2'b00;
    assign bus.fwd_b      = rst_n ? fwdSel[1] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stallCntReg <= '0;
        else if (!pcEn && (stallCntReg != '1))
            stallCntReg <= stallCntReg + CNT_W'(1);
    end

    assign stall_count = stallCntReg;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (main instance plus a CNT_W=2 saturation instance).
module tb_pipeline_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] stall_count;
    logic [1:0]  stall_count2;
    int          checks;
    int          passed;
    int          expStall;

    pipeline_ctrl_if bus ();
    pipeline_ctrl_if bus2 ();

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stall_count(stall_count)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .stall_count(stall_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_RegDest = 0; bus.ex_RegWrite = 0;
        bus.ex_MemRead = 0; bus.mem_RegDest = 0; bus.mem_RegWrite = 0;
        bus.wb_RegDest = 0; bus.wb_RegWrite = 0; bus.ex_PCSrc = 0; bus.mem_busy = 0;
    endtask

    task automatic clear_in2();
        bus2.id_rs1 = 0; bus2.id_rs2 = 0; bus2.id_use_rs1 = 0; bus2.id_use_rs2 = 0;
        bus2.ex_rs1 = 0; bus2.ex_rs2 = 0; bus2.ex_RegDest = 0; bus2.ex_RegWrite = 0;
        bus2.ex_MemRead = 0; bus2.mem_RegDest = 0; bus2.mem_RegWrite = 0;
        bus2.wb_RegDest = 0; bus2.wb_RegWrite = 0; bus2.ex_PCSrc = 0; bus2.mem_busy = 0;
    endtask

    task automatic set_load_use();
        bus.ex_MemRead = 1; bus.ex_RegWrite = 1; bus.ex_RegDest = 5;
        bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_in();
        clear_in2();
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en} !== 4'b0000)
            $display("FAIL rst_enables: got %b want 0000", {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en});
        else passed++;
        checks++;
        if ({bus.ifid_flush, bus.idex_flush} !== 2'b11)
            $display("FAIL rst_flushes: got %b want 11", {bus.ifid_flush, bus.idex_flush});
        else passed++;
        step();
        step();
        rst_n = 1;
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.ifid_flush, bus.idex_flush} !== 6'b111100)
            $display("FAIL run_ctrl: got %b want 111100",
                     {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.ifid_flush, bus.idex_flush});
        else passed++;
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b0000 || stall_count !== 16'd0)
            $display("FAIL run_fwd_cnt: got fwd %b cnt %0d want 0000 0", {bus.fwd_a, bus.fwd_b}, stall_count);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        step();
        set_load_use();
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush, bus.exmem_en, bus.ifid_flush} !== 5'b00110)
            $display("FAIL lu_stall: got %b want 00110",
                     {bus.pc_en, bus.ifid_en, bus.idex_flush, bus.exmem_en, bus.ifid_flush});
        else passed++;
        step();
        expStall++;
        bus.ex_MemRead = 0; bus.ex_RegWrite = 0; bus.ex_RegDest = 0;
        #1;
        checks++;
        if ({bus.pc_en, bus.idex_flush} !== 2'b10)
            $display("FAIL lu_bubble: got %b want 10", {bus.pc_en, bus.idex_flush});
        else passed++;
        checks++;
        if (stall_count !== 16'(expStall))
            $display("FAIL lu_count: got %0d want %0d", stall_count, expStall);
        else passed++;
        clear_in();
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        step();
        bus.ex_PCSrc = 1;
        set_load_use();
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush, bus.ifid_en, bus.exmem_en} !== 5'b11111)
            $display("FAIL br_cycle0: got %b want 11111",
                     {bus.pc_en, bus.ifid_flush, bus.idex_flush, bus.ifid_en, bus.exmem_en});
        else passed++;
        step();
        clear_in();
        bus.ex_PCSrc = 1;
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b111)
            $display("FAIL br_cycle1: got %b want 111", {bus.pc_en, bus.ifid_flush, bus.idex_flush});
        else passed++;
        step();
        bus.ex_PCSrc = 0;
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b100)
            $display("FAIL br_cycle2: got %b want 100", {bus.pc_en, bus.ifid_flush, bus.idex_flush});
        else passed++;
        checks++;
        if (stall_count !== 16'(expStall))
            $display("FAIL br_count: got %0d want %0d", stall_count, expStall);
        else passed++;
        $display("test_branch done");
    endtask

    task automatic test_forwarding();
        clear_in();
        bus.ex_rs1 = 7;
        bus.mem_RegDest = 7; bus.mem_RegWrite = 1;
        bus.wb_RegDest = 7;  bus.wb_RegWrite = 1;
        #1;
`ifdef PIPELINE_CTRL_FORWARDING_EN
        checks++;
        if (bus.fwd_a !== 2'b01) $display("FAIL fwd_mem: got %b want 01", bus.fwd_a);
        else passed++;
        bus.mem_RegWrite = 0;
        #1;
        checks++;
        if (bus.fwd_a !== 2'b10) $display("FAIL fwd_wb: got %b want 10", bus.fwd_a);
        else passed++;
        bus.ex_rs1 = 0; bus.mem_RegDest = 0; bus.mem_RegWrite = 1; bus.wb_RegDest = 0;
        #1;
        checks++;
        if (bus.fwd_a !== 2'b00) $display("FAIL fwd_x0: got %b want 00", bus.fwd_a);
        else passed++;
        bus.ex_rs2 = 9; bus.mem_RegDest = 9;
        #1;
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b0001) $display("FAIL fwd_b_mem: got %b want 0001", {bus.fwd_a, bus.fwd_b});
        else passed++;
`else
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) $display("FAIL fwd_off: got %b want 0000", {bus.fwd_a, bus.fwd_b});
        else passed++;
`endif
        clear_in();
        bus.mem_RegDest = 7; bus.mem_RegWrite = 1; bus.id_rs2 = 7; bus.id_use_rs2 = 1;
        #1;
        checks++;
`ifdef PIPELINE_CTRL_FORWARDING_EN
        if (bus.pc_en !== 1'b1) $display("FAIL raw_mem: got pc_en %b want 1", bus.pc_en);
        else passed++;
`else
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b001)
            $display("FAIL raw_mem: got %b want 001", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        else passed++;
`endif
        bus.id_use_rs2 = 0;
        #1;
        checks++;
        if (bus.pc_en !== 1'b1) $display("FAIL raw_unused_src: got pc_en %b want 1", bus.pc_en);
        else passed++;
        clear_in();
        bus.wb_RegDest = 0; bus.wb_RegWrite = 1; bus.id_rs1 = 0; bus.id_use_rs1 = 1;
        #1;
        checks++;
        if (bus.pc_en !== 1'b1) $display("FAIL raw_x0: got pc_en %b want 1", bus.pc_en);
        else passed++;
        clear_in();
        $display("test_forwarding done");
    endtask

    task automatic test_mem_wait();
        step();
        bus.ex_PCSrc = 1;
        step();
        bus.ex_PCSrc = 0;
        bus.mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.ifid_flush, bus.idex_flush} !== 6'b000000)
                $display("FAIL mw_freeze%0d: got %b want 000000", i,
                         {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.ifid_flush, bus.idex_flush});
            else passed++;
            step();
            expStall++;
        end
        bus.mem_busy = 0;
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b111)
            $display("FAIL mw_resume_flush: got %b want 111", {bus.pc_en, bus.ifid_flush, bus.idex_flush});
        else passed++;
        checks++;
        if (stall_count !== 16'(expStall))
            $display("FAIL mw_count: got %0d want %0d", stall_count, expStall);
        else passed++;
        step();
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b100)
            $display("FAIL mw_run: got %b want 100", {bus.pc_en, bus.ifid_flush, bus.idex_flush});
        else passed++;
        $display("test_mem_wait done");
    endtask

    task automatic test_reset_mid();
        step();
        bus.ex_PCSrc = 1;
        step();
        bus.ex_PCSrc = 0;
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b011 || stall_count !== 16'd0)
            $display("FAIL rm_flush_reset: got %b cnt %0d want 011 0",
                     {bus.pc_en, bus.ifid_flush, bus.idex_flush}, stall_count);
        else passed++;
        #1;
        rst_n = 1;
        expStall = 0;
        step();
        checks++;
        if ({bus.pc_en, bus.ifid_flush, bus.idex_flush} !== 3'b100)
            $display("FAIL rm_after_flush: got %b want 100", {bus.pc_en, bus.ifid_flush, bus.idex_flush});
        else passed++;
        set_load_use();
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.idex_en, bus.exmem_en, bus.ifid_flush} !== 3'b001)
            $display("FAIL rm_lu_reset: got %b want 001", {bus.idex_en, bus.exmem_en, bus.ifid_flush});
        else passed++;
        rst_n = 1;
        clear_in();
        #1;
        checks++;
        if ({bus.pc_en, bus.idex_flush} !== 2'b10 || stall_count !== 16'd0)
            $display("FAIL rm_after_lu: got %b cnt %0d want 10 0", {bus.pc_en, bus.idex_flush}, stall_count);
        else passed++;
        $display("test_reset_mid done");
    endtask

    task automatic test_saturation();
        step();
        bus2.ex_MemRead = 1; bus2.ex_RegWrite = 1; bus2.ex_RegDest = 3;
        bus2.id_rs2 = 3; bus2.id_use_rs2 = 1;
        step();
        step();
        checks++;
        if (stall_count2 !== 2'd2) $display("FAIL sat_two: got %0d want 2", stall_count2);
        else passed++;
        step();
        step();
        step();
        checks++;
        if (stall_count2 !== 2'd3) $display("FAIL sat_five: got %0d want 3", stall_count2);
        else passed++;
        clear_in2();
        $display("test_saturation done");
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        expStall = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_forwarding();
        test_mem_wait();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
